// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/host requesters, the arbiter and the data memory.
// The arbiter uses the slave view; the requester and memory side uses the master view.
interface dmem_arbiter_if;
    logic       core_req;
    logic       core_we;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic       core_gnt;
    logic       core_rvalid;
    logic [7:0] core_rdata;

    logic       host_req;
    logic       host_we;
    logic       host_lock;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;

    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_dat_in;
    logic [7:0] mem_dat_out;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_wr_en, mem_addr, mem_dat_in,
        input  mem_dat_out
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_wr_en, mem_addr, mem_dat_in,
        output mem_dat_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (core/host) data-memory arbiter with round-robin, host lock and core anti-starvation.
// Define DMEM_ARB_STATS_EN to enable the contention counter on stat_conflicts_o.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    dmem_arbiter_if.slave  bus,
    output logic [15:0]    stat_conflicts_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_HOST = 2'd2;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [1:0] state_q, state_d;
    logic       lock_q, lock_d;
    logic       last_core_q, last_core_d;
    logic [3:0] wait_q, wait_d;
    logic       core_rvalid_q, core_rvalid_d;
    logic       host_rvalid_q, host_rvalid_d;
    logic [7:0] core_rdata_q, core_rdata_d;
    logic [7:0] host_rdata_q, host_rdata_d;

    logic core_elig, host_elig;
    logic core_win, host_win;

    assign core_elig = bus.core_req & ~start_i;
    assign host_elig = bus.host_req;

    // Priority when both are eligible: starved core, then locked host, then round-robin.
    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        if (core_elig && host_elig) begin
            if (wait_q == WAIT_MAX) begin
                core_win = 1'b1;
            end else if (lock_q) begin
                host_win = 1'b1;
            end else if (last_core_q) begin
                host_win = 1'b1;
            end else begin
                core_win = 1'b1;
            end
        end else begin
            core_win = core_elig;
            host_win = host_elig;
        end
    end

    always_comb begin
        state_d       = state_q;
        lock_d        = lock_q;
        last_core_d   = last_core_q;
        wait_d        = wait_q;
        core_rvalid_d = 1'b0;
        host_rvalid_d = 1'b0;
        core_rdata_d  = core_rdata_q;
        host_rdata_d  = host_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (core_win) begin
                    state_d     = ST_CORE;
                    last_core_d = 1'b1;
                end else if (host_win) begin
                    state_d     = ST_HOST;
                    last_core_d = 1'b0;
                end
                if (!bus.host_req) begin
                    lock_d = 1'b0;
                end
                if (!bus.core_req || core_win) begin
                    wait_d = 4'd0;
                end else if (wait_q < WAIT_MAX) begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_CORE: begin
                state_d = ST_IDLE;
                if (!bus.core_we) begin
                    core_rvalid_d = 1'b1;
                    core_rdata_d  = bus.mem_dat_out;
                end
            end
            ST_HOST: begin
                state_d = ST_IDLE;
                lock_d  = bus.host_lock;
                if (!bus.host_we) begin
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = bus.mem_dat_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lock_q        <= 1'b0;
            last_core_q   <= 1'b0;
            wait_q        <= 4'd0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= 8'd0;
            host_rdata_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            last_core_q   <= last_core_d;
            wait_q        <= wait_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    // Writes are suppressed while reset is high, and for the core also while start is high.
    always_comb begin
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = 8'd0;
        bus.mem_dat_in = 8'd0;
        if (state_q == ST_CORE) begin
            bus.mem_wr_en  = bus.core_we & ~start_i & ~reset;
            bus.mem_addr   = bus.core_addr;
            bus.mem_dat_in = bus.core_wdata;
        end else if (state_q == ST_HOST) begin
            bus.mem_wr_en  = bus.host_we & ~reset;
            bus.mem_addr   = bus.host_addr;
            bus.mem_dat_in = bus.host_wdata;
        end
    end

    assign bus.core_gnt    = (state_q == ST_CORE);
    assign bus.host_gnt    = (state_q == ST_HOST);
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.core_rdata  = core_rdata_q;
    assign bus.host_rdata  = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q == ST_IDLE && core_elig && host_elig && stat_q != 16'hFFFF) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= 16'd0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_conflicts_o = stat_q;
`else
    assign stat_conflicts_o = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants are queued as stimulus is driven
// and popped by a negedge monitor whenever the arbiter issues a grant.
module tb_dmem_arbiter;

    typedef struct packed {
        logic       isHost;
        logic       we;
        logic       wen;
        logic [7:0] addr;
        logic [7:0] wdata;
    } grant_t;

`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] stat;
    int          checks = 0;
    int          errors = 0;

    grant_t      expQ[$];
    logic        rstSampled = 1'b1;
    logic        expCoreRv = 1'b0;
    logic        expHostRv = 1'b0;
    logic [7:0]  expCoreRd = 8'd0;
    logic [7:0]  expHostRd = 8'd0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start),
        .bus              (bus),
        .stat_conflicts_o (stat)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memModel(input logic [7:0] a);
        return a ^ 8'h1C;
    endfunction

    assign bus.mem_dat_out = memModel(bus.mem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [7:0] cAddr, input logic [7:0] cWd,
                                 input logic hReq, input logic hWe, input logic hLock,
                                 input logic [7:0] hAddr, input logic [7:0] hWd);
        bus.core_req   = cReq;
        bus.core_we    = cWe;
        bus.core_addr  = cAddr;
        bus.core_wdata = cWd;
        bus.host_req   = hReq;
        bus.host_we    = hWe;
        bus.host_lock  = hLock;
        bus.host_addr  = hAddr;
        bus.host_wdata = hWd;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushGrant(input logic isHost, input logic we, input logic wen,
                             input logic [7:0] addr, input logic [7:0] wdata);
        grant_t g;
        g.isHost = isHost;
        g.we     = we;
        g.wen    = wen;
        g.addr   = addr;
        g.wdata  = wdata;
        expQ.push_back(g);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    always @(posedge clk) rstSampled <= reset;

    // Monitor: read-data expectations follow grants by one cycle and are wiped by reset.
    always @(negedge clk) begin
        grant_t e;
        if (rstSampled) begin
            expCoreRv = 1'b0;
            expHostRv = 1'b0;
            expCoreRd = 8'd0;
            expHostRd = 8'd0;
        end
        checkOutput("core_rvalid", 32'(bus.core_rvalid), 32'(expCoreRv));
        checkOutput("host_rvalid", 32'(bus.host_rvalid), 32'(expHostRv));
        checkOutput("core_rdata", 32'(bus.core_rdata), 32'(expCoreRd));
        checkOutput("host_rdata", 32'(bus.host_rdata), 32'(expHostRd));
        expCoreRv = 1'b0;
        expHostRv = 1'b0;
        if (bus.core_gnt && bus.host_gnt) begin
            checkOutput("dual_gnt", {30'd0, bus.core_gnt, bus.host_gnt}, 32'd0);
        end else if (bus.core_gnt || bus.host_gnt) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_gnt", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("gnt_who", 32'(bus.host_gnt), 32'(e.isHost));
                checkOutput("mem_wr_en", 32'(bus.mem_wr_en), 32'(e.wen));
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                if (e.we) begin
                    checkOutput("mem_dat_in", 32'(bus.mem_dat_in), 32'(e.wdata));
                end else if (e.isHost) begin
                    expHostRv = 1'b1;
                    expHostRd = memModel(e.addr);
                end else begin
                    expCoreRv = 1'b1;
                    expCoreRd = memModel(e.addr);
                end
            end
        end else begin
            checkOutput("idle_mem", {15'd0, bus.mem_wr_en, bus.mem_addr, bus.mem_dat_in}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();
        doReset();
        checkOutput("rst_flags", {27'd0, bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid, bus.mem_wr_en}, 32'd0);
        checkOutput("rst_rdata", {16'd0, bus.core_rdata, bus.host_rdata}, 32'd0);
        checkOutput("rst_stat", 32'(stat), 32'd0);

        // Host-only write
        tick(1);
        pushGrant(1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
        tick(2);
        idleInputs();
        tick(2);
        checkOutput("q_host_wr", 32'(expQ.size()), 32'd0);

        // Core-only read; rdata must hold after the rvalid pulse
        pushGrant(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(2);
        idleInputs();
        tick(3);
        checkOutput("q_core_rd", 32'(expQ.size()), 32'd0);
        checkOutput("core_rdata_hold", 32'(bus.core_rdata), 32'h3C);

        // Both requesting without lock: strict alternation starting with core
        doReset();
        for (int i = 0; i < 2; i++) begin
            pushGrant(1'b0, 1'b1, 1'b1, 8'h30, 8'h11);
            pushGrant(1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        end
        applyStimulus(1'b1, 1'b1, 8'h30, 8'h11, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        tick(8);
        idleInputs();
        tick(2);
        checkOutput("q_alternate", 32'(expQ.size()), 32'd0);
        checkOutput("stat_alternate", 32'(stat), STATS_ON ? 32'd4 : 32'd0);

        // Host lock: 8 host grants then one forced core grant
        doReset();
        pushGrant(1'b0, 1'b1, 1'b1, 8'h31, 8'h22);
        for (int i = 0; i < 8; i++) pushGrant(1'b1, 1'b1, 1'b1, 8'h41, 8'h33);
        pushGrant(1'b0, 1'b1, 1'b1, 8'h31, 8'h22);
        for (int i = 0; i < 2; i++) pushGrant(1'b1, 1'b1, 1'b1, 8'h41, 8'h33);
        applyStimulus(1'b1, 1'b1, 8'h31, 8'h22, 1'b1, 1'b1, 1'b1, 8'h41, 8'h33);
        tick(24);
        idleInputs();
        tick(2);
        checkOutput("q_lock", 32'(expQ.size()), 32'd0);
        checkOutput("stat_lock", 32'(stat), STATS_ON ? 32'd12 : 32'd0);

        // start holds the core off; releasing it lets the core in at once
        doReset();
        start = 1'b1;
        for (int i = 0; i < 10; i++) pushGrant(1'b1, 1'b1, 1'b1, 8'h42, 8'h55);
        applyStimulus(1'b1, 1'b1, 8'h32, 8'h66, 1'b1, 1'b1, 1'b0, 8'h42, 8'h55);
        tick(20);
        start = 1'b0;
        pushGrant(1'b0, 1'b1, 1'b1, 8'h32, 8'h66);
        pushGrant(1'b1, 1'b1, 1'b1, 8'h42, 8'h55);
        tick(4);
        idleInputs();
        tick(2);
        checkOutput("q_start", 32'(expQ.size()), 32'd0);
        checkOutput("stat_start", 32'(stat), STATS_ON ? 32'd2 : 32'd0);

        // start rising during a core write grant suppresses the write
        pushGrant(1'b0, 1'b1, 1'b0, 8'h33, 8'h44);
        applyStimulus(1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        idleInputs();
        tick(2);
        checkOutput("q_start_core", 32'(expQ.size()), 32'd0);

        // Host read so host_rdata is non-zero before the reset case
        pushGrant(1'b1, 1'b0, 1'b0, 8'h66, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h66, 8'h00);
        tick(2);
        idleInputs();
        tick(2);
        checkOutput("host_rdata_pre", 32'(bus.host_rdata), 32'h7A);

        // Reset in the grant cycle of a host read: no rvalid follows
        pushGrant(1'b1, 1'b0, 1'b0, 8'h55, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00);
        tick(1);
        reset = 1'b1;
        tick(1);
        idleInputs();
        checkOutput("rst_rd_gnt", 32'(bus.host_gnt), 32'd0);
        checkOutput("rst_rd_rvalid", 32'(bus.host_rvalid), 32'd0);
        checkOutput("rst_rd_stat", 32'(stat), 32'd0);
        reset = 1'b0;
        tick(2);

        // Reset in the grant cycle of a host write: the write is blocked
        pushGrant(1'b1, 1'b1, 1'b0, 8'h77, 8'h88);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77, 8'h88);
        tick(1);
        reset = 1'b1;
        tick(1);
        idleInputs();
        reset = 1'b0;
        tick(2);
        checkOutput("q_reset", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 8, IDLE cycles a pending core request may lose before it is forced to win (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  core-hold; while high the core requester is ineligible.
REQ-005 core_req, core_we  input  1 each  core transfer pending / write qualifier.
REQ-006 core_addr, core_wdata  input  8 each  core address / write data.
REQ-007 core_gnt, core_rvalid  output  1 each  core grant / read-data valid.
REQ-008 core_rdata  output  8  core read data.
REQ-009 host_req, host_we, host_lock  input  1 each  host pending / write / keep-priority.
REQ-010 host_addr, host_wdata  input  8 each  host address / write data.
REQ-011 host_gnt, host_rvalid  output  1 each  host grant / read-data valid.
REQ-012 host_rdata  output  8  host read data.
REQ-013 mem_wr_en  output  1  data-memory write enable.
REQ-014 mem_addr, mem_dat_in  output  8 each  data-memory address / write data.
REQ-015 mem_dat_out  input  8  data-memory combinational read data.
REQ-016 stat_conflicts  output  16  contention counter (see Configuration).

Function
REQ-017 FSM states: IDLE, CORE, HOST; CORE and HOST always return to IDLE on the next edge (one transfer = 2 cycles).
REQ-018 In IDLE, requests are sampled; winner moves FSM to CORE or HOST; no request -> stay IDLE.
REQ-019 core_gnt = (state==CORE); host_gnt = (state==HOST); both never high together.
REQ-020 In CORE/HOST, mem_addr and mem_dat_in come from the granted requester; in IDLE they are 0.
REQ-021 mem_wr_en = granted requester's we during its grant cycle; 0 in IDLE.
REQ-022 Read grant (we=0): mem_dat_out captured at end of grant cycle into that requester's rdata; its rvalid pulses high exactly the following cycle; rdata holds until next read capture.
REQ-023 Requester must deassert or change req/addr/data in the cycle after its gnt; req seen in IDLE is always a new transfer.
REQ-024 Eligibility: core eligible iff core_req & ~start; host eligible iff host_req.
REQ-025 Arbitration order, one eligible: it wins; both eligible: (a) core_wait==MAX_WAIT -> core, (b) lock_r -> host, (c) else the requester not served last (round-robin).
REQ-026 lock_r set on a HOST grant with host_lock=1; cleared on a HOST grant with host_lock=0, or in any IDLE cycle with host_req=0.
REQ-027 core_wait increments (saturating at MAX_WAIT) in each IDLE cycle where core_req=1 and core loses or is ineligible; cleared on a CORE grant or when core_req=0 in IDLE.
REQ-028 start overrides starvation: core never granted while start=1, even with core_wait==MAX_WAIT.
REQ-029 start rising while in CORE state does not abort the in-flight grant, but mem_wr_en is forced 0 for that cycle.

Reset
REQ-030 On reset: state=IDLE, all gnt/rvalid/mem_wr_en=0, rdata=0, lock_r=0, core_wait=0, last-served=HOST, stat_conflicts=0.
REQ-031 Reset during CORE/HOST: no write issued that cycle if reset is high; no rvalid follows.

Configuration
REQ-032 Macro DMEM_ARB_STATS_EN defined: stat_conflicts counts IDLE cycles with both requesters eligible, saturating at 16'hFFFF.
REQ-033 Macro not defined: counter logic omitted, stat_conflicts tied to 0; port list unchanged.

Verification
REQ-034 Host-only write addr 0x10 data 0xA5 -> host_gnt 1 cycle after req, mem_wr_en=1, mem_addr=0x10, mem_dat_in=0xA5.
REQ-035 Core read addr 0x20, mem_dat_out=0x3C -> core_rvalid high one cycle after core_gnt, core_rdata=0x3C.
REQ-036 Both requesting continuously after reset, no lock -> grants alternate CORE,HOST,CORE,HOST.
REQ-037 host_lock=1, both requesting continuously, MAX_WAIT=8 -> 8 host grants, then 1 forced core grant, then host resumes.
REQ-038 start=1 with both requesting for 20 cycles -> only host_gnt pulses, core_gnt=0, core_wait saturates at 8; start=0 -> core granted next arbitration.
REQ-039 Reset asserted in HOST grant cycle of a read -> next cycle IDLE, host_rvalid=0; with DMEM_ARB_STATS_EN, stat_conflicts=0.
